csr_file: RTL and testbench
===========================

# csr_file

Machine-mode CSR file for the RV32I core, replacing the fixed single-write-port register set with a parametrised block. It supports CSRRW/CSRRS/CSRRC read-modify-write, an atomic trap-entry/mret sequencer, 64-bit cycle/instret counters with inhibit, optional hardware performance counters, and illegal-access detection. It sits beside EX (instruction port) and CLINT (trap port) and drives trap vector, return address and interrupt request to the pipeline control.

## Interface
- NUM_HPM, 4: number of mhpmcounter3.. instances (0-8); used only with CSR_HPM_EN.
- HPM_W, 40: width of each HPM counter (33-64); upper bits above HPM_W read 0.
- MISA_VAL, 32'h4000_0100: constant returned by misa (RV32I).
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- csr_op_i  in  2  00 none, 01 write, 10 set, 11 clear.
- csr_addr_i  in  12  CSR address from EX.
- csr_wdata_i  in  32  operand (rs1 or zimm).
- csr_rdata_o  out  32  combinational old value of csr_addr_i.
- csr_illegal_o  out  1  combinational: op!=00 and (address unimplemented, or write/set/clear with addr[11:10]==2'b11 and nonzero operand).
- trap_i  in  1  one-cycle trap-entry strobe from CLINT.
- trap_cause_i  in  32  mcause value (bit31 = interrupt).
- trap_epc_i  in  32  faulting/interrupted PC.
- trap_val_i  in  32  mtval value.
- mret_i  in  1  one-cycle mret strobe.
- instret_i  in  1  one instruction retired this cycle.
- hpm_evt_i  in  NUM_HPM  per-counter event pulses (CSR_HPM_EN only).
- irq_ext_i, irq_timer_i, irq_soft_i  in  1 each  level interrupt lines.
- trap_pc_o  out  32  vector target for current trap_cause_i.
- mepc_o  out  32  mret target.
- int_req_o  out  1  mstatus.MIE & |(mip & mie).

## Operation
- Map: mstatus 300, misa 301 (RO), mie 304, mtvec 305, mcountinhibit 320, mscratch 340, mepc 341, mcause 342, mtval 343, mip 344 (RO), mcycle/h B00/B80, minstret/h B02/B82, mhpmcounterN/h B00+N/B80+N, user shadows cycle C00/C80, instret C02/C82, hpmcounterN C00+N/C80+N (RO).
- New value: write = wdata; set = old|wdata; clear = old&~wdata; then masked.
- Masks: mstatus only MIE(3), MPIE(7), MPP(12:11) reads 2'b11 fixed; mie only bits 3,7,11; mtvec[1] = 0; mepc[1:0] = 0; mcountinhibit bits 0,2 and 3..2+NUM_HPM.
- Illegal ops update nothing. Set/clear with zero operand perform no write (no illegal on RO).
- mip = {irq_ext_i<<11 | irq_timer_i<<7 | irq_soft_i<<3}, sampled live.
- Trap entry: mepc <= trap_epc_i&~3; mcause <= trap_cause_i; mtval <= trap_val_i; MPIE <= MIE; MIE <= 0.
- mret: MIE <= MPIE; MPIE <= 1.
- Priority same cycle: trap > mret > EX op; lower-priority action dropped entirely (EX instruction is flushed).
- trap_pc_o: mtvec[0]==1 and cause[31]==1 → {mtvec[31:2],2'b00} + 4*cause[4:0]; else {mtvec[31:2],2'b00}.
- Counters: mcycle +1 every cycle unless inhibit[0]; minstret +1 on instret_i unless inhibit[2]; HPM N +1 on hpm_evt_i[N-3] unless inhibit[N]. Wrap 2^W-1 → 0. Writing a half replaces that half only; in that cycle the written value stands and the increment is lost.

## Timing
- Reset (rst=0, async): all CSRs 0 except mstatus.MPP reads 2'b11; counters 0; trap_pc_o = 0, mepc_o = 0, int_req_o = 0.
- Reads combinational, zero latency, return pre-write value; writes visible next cycle.
- Trap/mret effects visible on cycle after strobe; int_req_o deasserts the cycle after trap_i.
- Reset mid-operation: all state cleared asynchronously; a strobe coincident with reset release is ignored.

## Configuration
- CSR_HPM_EN defined: NUM_HPM counters, events and inhibit bits implemented.
- Undefined: hpm_evt_i ignored, B03-B1F/B83-B9F/C03-C1F/C83-C9F read 0 and are legal, writes discarded, inhibit bits 3+ read 0.

## Test plan
- Reset then read 300 → 0x0000_1800; read 7C0 → csr_illegal_o=1, no state change.
- Write mstatus 0xFFFF_FFFF, set mie 0x888 → mstatus 0x1888, mie 0x888; irq_timer_i=1 → int_req_o=1.
- trap_i with cause 0x8000_0007, epc 0x103, mtvec 0x8000_0001 → mepc 0x100, trap_pc_o 0x8000_001C, MIE 0, MPIE 1; mret next → MIE 1.
- Write mcycle 0xFFFF_FFFF, mcycleh 0 → after 1 cycle reads 0x1_0000_0000; write mcycleh 0xFFFF_FFFF with low full → wraps to 0.
- trap_i and csr write of mscratch same cycle → mscratch unchanged; clear C00 with zero operand → legal, no change.
- CSR_HPM_EN, NUM_HPM=4, HPM_W=40: 5 pulses on hpm_evt_i[0] with inhibit[3]=0 → B03 = 5; set inhibit[3] → count frozen.

Source files
------------

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file for the RV32I core.
// Handles CSRRW/CSRRS/CSRRC read-modify-write, trap entry and mret, 64-bit
// cycle/instret counters with inhibit, and illegal-access detection.
// Optional feature: define CSR_HPM_EN to build NUM_HPM hardware performance
// counters (mhpmcounter3..) together with their events and inhibit bits.
module csr_file #(
  parameter int          NUM_HPM  = 4,
  parameter int          HPM_W    = 40,
  parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        trap_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_epc_i,
  input  logic [31:0] trap_val_i,
  input  logic        mret_i,
  input  logic        instret_i,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_evt_i,
  input  logic        irq_ext_i,
  input  logic        irq_timer_i,
  input  logic        irq_soft_i,
  output logic [31:0] trap_pc_o,
  output logic [31:0] mepc_o,
  output logic        int_req_o
);

  localparam int          NH       = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam logic [31:0] MIE_MASK = 32'h0000_0888;
`ifdef CSR_HPM_EN
  localparam logic [31:0] INH_MASK = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);
`else
  localparam logic [31:0] INH_MASK = 32'h5;
`endif

  logic        mstatus_mie_q, mstatus_mpie_q;
  logic [31:0] mie_q, mtvec_q, inhibit_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

  logic [31:0] mip, mstatus_rd, old_val, new_val;
  logic [63:0] ctr_val;
  logic        impl, ctr_rng, ro_space, wr_en;
  logic [4:0]  cidx;

  // Counter window: B00-B1F/B80-B9F and the C-shadows, minus the x01 (time) slot
  assign cidx     = csr_addr_i[4:0];
  assign ro_space = (csr_addr_i[11:10] == 2'b11);
  assign ctr_rng  = ((csr_addr_i[11:8] == 4'hB) || (csr_addr_i[11:8] == 4'hC)) &&
                    (csr_addr_i[6:5] == 2'b00) && (cidx != 5'd1);

  assign mip        = {20'b0, irq_ext_i, 3'b0, irq_timer_i, 3'b0, irq_soft_i, 3'b0};
  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};

`ifdef CSR_HPM_EN
  logic [NH-1:0][63:0] hpm_rd;
`endif

  // Select the 64-bit counter addressed by the low index bits
  always_comb begin
    ctr_val = 64'd0;
    if (cidx == 5'd0)      ctr_val = mcycle_q;
    else if (cidx == 5'd2) ctr_val = minstret_q;
`ifdef CSR_HPM_EN
    for (int g = 0; g < NUM_HPM; g++)
      if (cidx == 5'(g + 3)) ctr_val = hpm_rd[g];
`endif
  end

  // Combinational read of the pre-write value plus implemented-address decode
  always_comb begin
    impl    = 1'b1;
    old_val = 32'd0;
    case (csr_addr_i)
      12'h300: old_val = mstatus_rd;
      12'h301: old_val = MISA_VAL;
      12'h304: old_val = mie_q;
      12'h305: old_val = mtvec_q;
      12'h320: old_val = inhibit_q;
      12'h340: old_val = mscratch_q;
      12'h341: old_val = mepc_q;
      12'h342: old_val = mcause_q;
      12'h343: old_val = mtval_q;
      12'h344: old_val = mip;
      default: begin
        impl = ctr_rng;
        if (ctr_rng) old_val = csr_addr_i[7] ? ctr_val[63:32] : ctr_val[31:0];
      end
    endcase
  end

  // Read-modify-write result before per-register masking
  always_comb begin
    case (csr_op_i)
      2'b10:   new_val = old_val | csr_wdata_i;
      2'b11:   new_val = old_val & ~csr_wdata_i;
      default: new_val = csr_wdata_i;
    endcase
  end

  assign csr_rdata_o   = old_val;
  assign csr_illegal_o = (csr_op_i != 2'b00) &&
                         (!impl || (ro_space && (csr_wdata_i != 32'd0)));
  // A trap or mret in the same cycle flushes the EX instruction entirely.
  // Zero-operand set/clear never writes; RO space never writes.
  assign wr_en = (csr_op_i != 2'b00) && !csr_illegal_o &&
                 !(csr_op_i[1] && (csr_wdata_i == 32'd0)) &&
                 !trap_i && !mret_i && !ro_space;

  // Machine status/trap registers: trap beats mret beats EX write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= 32'd0;
      mtvec_q        <= 32'd0;
      inhibit_q      <= 32'd0;
      mscratch_q     <= 32'd0;
      mepc_q         <= 32'd0;
      mcause_q       <= 32'd0;
      mtval_q        <= 32'd0;
    end else if (trap_i) begin
      mepc_q         <= {trap_epc_i[31:2], 2'b00};
      mcause_q       <= trap_cause_i;
      mtval_q        <= trap_val_i;
      mstatus_mpie_q <= mstatus_mie_q;
      mstatus_mie_q  <= 1'b0;
    end else if (mret_i) begin
      mstatus_mie_q  <= mstatus_mpie_q;
      mstatus_mpie_q <= 1'b1;
    end else if (wr_en) begin
      case (csr_addr_i)
        12'h300: begin
          mstatus_mie_q  <= new_val[3];
          mstatus_mpie_q <= new_val[7];
        end
        12'h304: mie_q      <= new_val & MIE_MASK;
        12'h305: mtvec_q    <= new_val & ~32'h2;
        12'h320: inhibit_q  <= new_val & INH_MASK;
        12'h340: mscratch_q <= new_val;
        12'h341: mepc_q     <= {new_val[31:2], 2'b00};
        12'h342: mcause_q   <= new_val;
        12'h343: mtval_q    <= new_val;
        default: ;
      endcase
    end
  end

  // Counter next state: a half-write wins over that cycle's increment
  always_comb begin
    mcycle_d   = inhibit_q[0] ? mcycle_q : mcycle_q + 64'd1;
    minstret_d = (instret_i && !inhibit_q[2]) ? minstret_q + 64'd1 : minstret_q;
    if (wr_en) begin
      case (csr_addr_i)
        12'hB00: mcycle_d   = {mcycle_q[63:32], new_val};
        12'hB80: mcycle_d   = {new_val, mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[63:32], new_val};
        12'hB82: minstret_d = {new_val, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

`ifdef CSR_HPM_EN
  for (genvar g = 0; g < NUM_HPM; g++) begin : g_hpm
    logic [HPM_W-1:0] cnt_q, cnt_d;
    logic             wr_lo, wr_hi;

    assign wr_lo = wr_en && (csr_addr_i == 12'hB03 + 12'(g));
    assign wr_hi = wr_en && (csr_addr_i == 12'hB83 + 12'(g));

    // Event count with inhibit; a half-write replaces the increment
    always_comb begin
      cnt_d = (hpm_evt_i[g] && !inhibit_q[g+3]) ? cnt_q + HPM_W'(1) : cnt_q;
      if (wr_lo) begin
        cnt_d       = cnt_q;
        cnt_d[31:0] = new_val;
      end
      if (wr_hi) begin
        cnt_d             = cnt_q;
        cnt_d[HPM_W-1:32] = new_val[HPM_W-33:0];
      end
    end

    // HPM counter register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign hpm_rd[g] = 64'(cnt_q);
  end
  for (genvar g = NUM_HPM; g < NH; g++) begin : g_hpm_pad
    assign hpm_rd[g] = 64'd0;
  end
`else
  logic unused_hpm;
  assign unused_hpm = ^{hpm_evt_i, (HPM_W > 0)};
`endif

  // Trap vector: vectored mode offsets interrupts by 4*cause
  always_comb begin
    trap_pc_o = {mtvec_q[31:2], 2'b00};
    if (mtvec_q[0] && trap_cause_i[31])
      trap_pc_o = {mtvec_q[31:2], 2'b00} + {25'd0, trap_cause_i[4:0], 2'b00};
  end

  assign mepc_o    = mepc_q;
  assign int_req_o = mstatus_mie_q & (|(mip & mie_q));

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed checks from the CSR test plan followed by randomized
// CSR/trap/counter traffic compared against an architectural model.
module tb_csr_file;
  localparam int          NUM_HPM = 4;
  localparam int          HPM_W   = 40;
  localparam logic [31:0] MISA    = 32'h4000_0100;
  localparam logic [63:0] HMASK   = (64'd1 << HPM_W) - 64'd1;
`ifdef CSR_HPM_EN
  localparam bit HPM_ON = 1'b1;
`else
  localparam bit HPM_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        csr_illegal;
  logic        trap, mret, instret;
  logic [31:0] cause, epc, tval;
  logic [NUM_HPM-1:0] evt;
  logic        irq_e, irq_t, irq_s;
  logic [31:0] trap_pc, mepc_out;
  logic        int_req;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  csr_file #(.NUM_HPM(NUM_HPM), .HPM_W(HPM_W), .MISA_VAL(MISA)) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_op_i(csr_op), .csr_addr_i(csr_addr), .csr_wdata_i(csr_wdata),
    .csr_rdata_o(csr_rdata), .csr_illegal_o(csr_illegal),
    .trap_i(trap), .trap_cause_i(cause), .trap_epc_i(epc), .trap_val_i(tval),
    .mret_i(mret), .instret_i(instret), .hpm_evt_i(evt),
    .irq_ext_i(irq_e), .irq_timer_i(irq_t), .irq_soft_i(irq_s),
    .trap_pc_o(trap_pc), .mepc_o(mepc_out), .int_req_o(int_req)
  );

  // ---------------- architectural model ----------------
  bit          m_mie, m_mpie;
  logic [31:0] m_ie, m_tvec, m_inh, m_scr, m_epc, m_cause, m_tval;
  logic [63:0] m_cyc, m_ins;
  logic [63:0] m_hpm [8];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_mie = 0; m_mpie = 0;
    m_ie = 0; m_tvec = 0; m_inh = 0; m_scr = 0; m_epc = 0; m_cause = 0; m_tval = 0;
    m_cyc = 0; m_ins = 0;
    for (int i = 0; i < 8; i++) m_hpm[i] = 0;
  endfunction

  function automatic logic [31:0] inh_mask();
    logic [31:0] m = 32'h5;
    if (HPM_ON) for (int i = 0; i < NUM_HPM; i++) m = m | (32'h1 << (3 + i));
    return m;
  endfunction

  function automatic bit is_ctr(input logic [11:0] a);
    int off;
    if ((a >= 12'hB00 && a <= 12'hB1F) || (a >= 12'hB80 && a <= 12'hB9F) ||
        (a >= 12'hC00 && a <= 12'hC1F) || (a >= 12'hC80 && a <= 12'hC9F)) begin
      off = int'(a) % 32;
      return off != 1;
    end
    return 0;
  endfunction

  function automatic bit m_impl(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h320,
      12'h340, 12'h341, 12'h342, 12'h343, 12'h344: return 1;
      default: return is_ctr(a);
    endcase
  endfunction

  function automatic logic [31:0] m_mip();
    return (32'(irq_e) << 11) | (32'(irq_t) << 7) | (32'(irq_s) << 3);
  endfunction

  function automatic logic [63:0] m_ctr(input int idx);
    if (idx == 0) return m_cyc;
    if (idx == 2) return m_ins;
    if (HPM_ON && idx >= 3 && idx - 3 < NUM_HPM) return m_hpm[idx-3];
    return 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    logic [63:0] v;
    case (a)
      12'h300: return 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
      12'h301: return MISA;
      12'h304: return m_ie;
      12'h305: return m_tvec;
      12'h320: return m_inh;
      12'h340: return m_scr;
      12'h341: return m_epc;
      12'h342: return m_cause;
      12'h343: return m_tval;
      12'h344: return m_mip();
      default: begin
        if (!is_ctr(a)) return 0;
        v = m_ctr(int'(a) % 32);
        return ((int'(a) / 128) % 2 == 1) ? v[63:32] : v[31:0];
      end
    endcase
  endfunction

  function automatic bit m_illegal();
    if (csr_op == 0) return 0;
    return !m_impl(csr_addr) || (csr_addr >= 12'hC00 && csr_wdata != 0);
  endfunction

  function automatic bit m_intreq();
    return m_mie && ((m_mip() & m_ie) != 0);
  endfunction

  function automatic logic [31:0] m_trap_pc();
    logic [31:0] base = m_tvec & ~32'h3;
    if (m_tvec[0] && cause[31]) return base + 32'(4 * int'(cause[4:0]));
    return base;
  endfunction

  // One clock edge worth of architectural effect
  function automatic void m_step();
    logic [31:0] old, nv, inh0;
    logic [63:0] cyc0, ins0;
    logic [63:0] h0 [8];
    bit we;
    int n;
    old = m_read(csr_addr);
    inh0 = m_inh; cyc0 = m_cyc; ins0 = m_ins; h0 = m_hpm;
    nv = (csr_op == 1) ? csr_wdata : (csr_op == 2) ? (old | csr_wdata) : (old & ~csr_wdata);
    we = csr_op != 0 && !m_illegal() && !(csr_op >= 2 && csr_wdata == 0) &&
         !trap && !mret && csr_addr < 12'hC00;
    if (!inh0[0]) m_cyc = cyc0 + 1;
    if (instret && !inh0[2]) m_ins = ins0 + 1;
    if (HPM_ON)
      for (int i = 0; i < NUM_HPM; i++)
        if (evt[i] && !inh0[3+i]) m_hpm[i] = (h0[i] + 1) & HMASK;
    if (trap) begin
      m_epc = epc & ~32'h3; m_cause = cause; m_tval = tval;
      m_mpie = m_mie; m_mie = 0;
    end else if (mret) begin
      m_mie = m_mpie; m_mpie = 1;
    end else if (we) begin
      case (csr_addr)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h304: m_ie = nv & 32'h888;
        12'h305: m_tvec = nv & ~32'h2;
        12'h320: m_inh = nv & inh_mask();
        12'h340: m_scr = nv;
        12'h341: m_epc = nv & ~32'h3;
        12'h342: m_cause = nv;
        12'h343: m_tval = nv;
        12'hB00: m_cyc = {cyc0[63:32], nv};
        12'hB80: m_cyc = {nv, cyc0[31:0]};
        12'hB02: m_ins = {ins0[63:32], nv};
        12'hB82: m_ins = {nv, ins0[31:0]};
        default: begin
          n = int'(csr_addr) - 'hB03;
          if (HPM_ON && n >= 0 && n < NUM_HPM) m_hpm[n] = {h0[n][63:32], nv} & HMASK;
          n = int'(csr_addr) - 'hB83;
          if (HPM_ON && n >= 0 && n < NUM_HPM) m_hpm[n] = {nv, h0[n][31:0]} & HMASK;
        end
      endcase
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drv(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_op = op; csr_addr = a; csr_wdata = d;
  endtask

  task automatic idle();
    drv(2'b00, 12'h300, 32'd0);
    trap = 0; mret = 0; evt = '0;
    cause = 0; epc = 0; tval = 0;
  endtask

  // Check every output against the model, then clock and advance the model
  task automatic tick();
    #1;
    chk("rdata", csr_rdata, m_read(csr_addr));
    chk("illegal", csr_illegal, m_illegal());
    chk("int_req", int_req, m_intreq());
    chk("trap_pc", trap_pc, m_trap_pc());
    chk("mepc", mepc_out, m_epc);
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    #1 m_reset();
    chk("rst_mepc", mepc_out, 32'd0);
    chk("rst_int_req", int_req, 1'b0);
    chk("rst_trap_pc", trap_pc, 32'd0);
    @(negedge clk);
    rst_n = 1;
    #1;
  endtask

  function automatic logic [11:0] pick_addr(input int k);
    case (k)
      0: return 12'h300;  1: return 12'h301;  2: return 12'h304;  3: return 12'h305;
      4: return 12'h320;  5: return 12'h340;  6: return 12'h341;  7: return 12'h342;
      8: return 12'h343;  9: return 12'h344; 10: return 12'hB00; 11: return 12'hB80;
     12: return 12'hB02; 13: return 12'hB82; 14: return 12'hC00; 15: return 12'hC80;
     16: return 12'hC02; 17: return 12'hC82; 18: return 12'hB03; 19: return 12'hB04;
     20: return 12'hB06; 21: return 12'hB83; 22: return 12'hB86; 23: return 12'hC03;
     24: return 12'hC83; 25: return 12'hB1F; 26: return 12'hB01; 27: return 12'h7C0;
     28: return 12'hB07; default: return 12'($urandom);
    endcase
  endfunction

  task automatic rand_drive();
    logic [31:0] d;
    case ($urandom_range(0, 3))
      0: d = 32'd0;
      1: d = $urandom;
      2: d = 32'hFFFF_FFFF;
      default: d = 32'h1 << $urandom_range(0, 31);
    endcase
    drv(2'($urandom), pick_addr($urandom_range(0, 29)), d);
    trap    = ($urandom_range(0, 19) == 0);
    mret    = ($urandom_range(0, 19) == 0);
    cause   = {1'($urandom), 26'd0, 5'($urandom)};
    epc     = $urandom;
    tval    = $urandom;
    instret = 1'($urandom);
    evt     = NUM_HPM'($urandom);
    if ($urandom_range(0, 9) == 0) begin
      irq_e = 1'($urandom); irq_t = 1'($urandom); irq_s = 1'($urandom);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    idle();
    instret = 0; irq_e = 0; irq_t = 0; irq_s = 0;
    m_reset();
    #12;
    chk("rst_mstatus", csr_rdata, 32'h1800);
    chk("rst_trap_pc", trap_pc, 32'd0);
    chk("rst_mepc", mepc_out, 32'd0);
    chk("rst_int_req", int_req, 1'b0);
    csr_addr = 12'hB00; #1;
    chk("rst_mcycle", csr_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1;
    #1;

    // Unimplemented address
    drv(2'b01, 12'h7C0, 32'hFFFF_FFFF); #1;
    chk("ill_7c0", csr_illegal, 1'b1);
    tick();

    // mstatus/mie masking and interrupt request
    drv(2'b01, 12'h300, 32'hFFFF_FFFF); tick();
    drv(2'b10, 12'h304, 32'h888); tick();
    drv(2'b00, 12'h300, 32'd0); #1;
    chk("mstatus_mask", csr_rdata, 32'h1888);
    tick();
    drv(2'b00, 12'h304, 32'd0); #1;
    chk("mie_mask", csr_rdata, 32'h888);
    irq_t = 1; #1;
    chk("int_req_timer", int_req, 1'b1);
    tick();

    // Vectored trap entry then mret
    drv(2'b01, 12'h305, 32'h8000_0001); tick();
    drv(2'b00, 12'h300, 32'd0);
    trap = 1; cause = 32'h8000_0007; epc = 32'h103; tval = 32'hDEAD; #1;
    chk("trap_pc_vec", trap_pc, 32'h8000_001C);
    tick();
    trap = 0; #1;
    chk("mepc_trap", mepc_out, 32'h100);
    chk("mstatus_trap", csr_rdata, 32'h1880);
    chk("int_req_off", int_req, 1'b0);
    tick();
    mret = 1; tick();
    mret = 0; #1;
    chk("mstatus_mret", csr_rdata, 32'h1888);
    tick();

    // mcycle carry across halves and full wrap
    drv(2'b01, 12'hB00, 32'hFFFF_FFFF); tick();
    drv(2'b01, 12'hB80, 32'd0); tick();
    drv(2'b00, 12'hB80, 32'd0); tick();
    #1 chk("mcycle_carry_hi", csr_rdata, 32'd1);
    csr_addr = 12'hB00; #1;
    chk("mcycle_carry_lo", csr_rdata, 32'd0);
    drv(2'b01, 12'h320, 32'd1); tick();
    drv(2'b01, 12'hB00, 32'hFFFF_FFFF); tick();
    drv(2'b01, 12'hB80, 32'hFFFF_FFFF); tick();
    drv(2'b01, 12'h320, 32'd0); tick();
    drv(2'b00, 12'hB80, 32'd0); #1;
    chk("mcycle_full_hi", csr_rdata, 32'hFFFF_FFFF);
    tick();
    #1 chk("mcycle_wrap_hi", csr_rdata, 32'd0);
    csr_addr = 12'hB00; #1;
    chk("mcycle_wrap_lo", csr_rdata, 32'd0);
    tick();

    // Trap flushes a same-cycle CSR write
    drv(2'b01, 12'h340, 32'h1234); tick();
    drv(2'b01, 12'h340, 32'hDEAD);
    trap = 1; cause = 32'd2; epc = 32'h200; tick();
    trap = 0; drv(2'b00, 12'h340, 32'd0); #1;
    chk("mscratch_trap", csr_rdata, 32'h1234);
    tick();

    // Read-only shadow access rules
    drv(2'b11, 12'hC00, 32'd0); #1;
    chk("clr_c00_zero", csr_illegal, 1'b0);
    tick();
    drv(2'b01, 12'hC00, 32'd5); #1;
    chk("wr_c00_nz", csr_illegal, 1'b1);
    tick();

`ifdef CSR_HPM_EN
    drv(2'b00, 12'hB03, 32'd0);
    repeat (5) begin evt = 4'b0001; tick(); end
    evt = '0; #1;
    chk("hpm3_count", csr_rdata, 32'd5);
    tick();
    drv(2'b10, 12'h320, 32'h8); tick();
    drv(2'b00, 12'hB03, 32'd0);
    repeat (3) begin evt = 4'b0001; tick(); end
    evt = '0; #1;
    chk("hpm3_frozen", csr_rdata, 32'd5);
    drv(2'b11, 12'h320, 32'h8); tick();
`else
    drv(2'b00, 12'hB03, 32'd0);
    repeat (2) begin evt = 4'b1111; tick(); end
    evt = '0; #1;
    chk("hpm3_absent", csr_rdata, 32'd0);
    drv(2'b01, 12'hB03, 32'd5); #1;
    chk("hpm3_wr_legal", csr_illegal, 1'b0);
    tick();
    drv(2'b10, 12'h320, 32'h8); tick();
    drv(2'b00, 12'h320, 32'd0); #1;
    chk("inh3_absent", csr_rdata, 32'd0);
    tick();
`endif

    // Randomized traffic with occasional asynchronous reset
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      rand_drive();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
